pingpong_bram_ctrl: RTL and testbench

PINGPONG_BRAM_CTRL -- requirements
Module: pingpong_bram_ctrl

---
 rtl/pingpong_bram_ctrl_pkg.sv | 6 +
 rtl/pingpong_bram_ctrl_lat.sv | 23 ++
 rtl/pingpong_bram_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pingpong_bram_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_bram_ctrl_pkg.sv
// pingpong_bram_ctrl_pkg: shared state encodings and constants for the ping-pong BRAM controller
package pingpong_bram_ctrl_pkg;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_e;
  typedef enum logic {R_IDLE, R_READ} rd_state_e;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/pingpong_bram_ctrl_lat.sv
// lat_align_sr: delays the read-side {valid,first,last} tags so they line up with RAM read data
module lat_align_sr
  import pingpong_bram_ctrl_pkg::*;
#(
  parameter int RD_LAT = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_din,
  output logic [2:0] o_dout
);
  logic [2:0] sr_q [RD_LAT];
  logic [2:0] sr_d [RD_LAT];
  always_comb begin
    sr_d[0] = i_din;
    for (int i = 1; i < RD_LAT; i++) sr_d[i] = sr_q[i-1];
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sr_q <= '{default: '0};
    else sr_q <= sr_d;
  end
  assign o_dout = sr_q[RD_LAT-1];
endmodule

// File: rtl/pingpong_bram_ctrl.sv
// pingpong_bram_ctrl: two-bank ping-pong frame buffer controller driving an external BRAM.
// Frames of DEPTH words are written into alternating banks and read out whole once a bank is full.
module pingpong_bram_ctrl
  import pingpong_bram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int RD_LAT = 4,
  localparam int AW = $clog2(DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_vld,
  input  logic                  i_wr_sop,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_ram_wren,
  output logic [AW-1:0]         o_ram_wraddr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_ram_rden,
  output logic [AW-1:0]         o_ram_rdaddr,
  input  logic [DATA_WIDTH-1:0] i_ram_q,
  output logic                  o_rd_vld,
  output logic                  o_rd_sop,
  output logic                  o_rd_eop,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [1:0]            o_bank_full,
  output logic                  o_drop,
  output logic                  o_sop_err,
  output logic [15:0]           o_drop_cnt
);
  localparam int IW = AW - 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  wr_state_e wst_q, wst_d;
  rd_state_e rdst_q, rdst_d;
  logic [1:0] bank_full_q, bank_full_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d, idx_w;
  logic set_pend_q, set_pend_d, set_bank_q, set_bank_d, clr;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic drop_q, drop_d, sop_err_q, sop_err_d;
  logic wren_q, wren_d, rden_q, rden_d;
  logic [AW-1:0] wraddr_q, wraddr_d, rdaddr_q, rdaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0] sr_out;
  assign idx_w = i_wr_sop ? '0 : wr_idx_q;
  // Completed banks are flagged one cycle late so the last registered write lands before reading starts.
  always_comb begin
    wst_d = wst_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d = wr_idx_q;
    set_pend_d = 1'b0;
    set_bank_d = set_bank_q;
    drop_d = 1'b0;
    sop_err_d = 1'b0;
    drop_cnt_d = drop_cnt_q;
    wren_d = 1'b0;
    wraddr_d = wraddr_q;
    wdata_d = wdata_q;
    if (wst_q == W_FILL) begin
      if (i_wr_vld) begin
        wren_d = 1'b1;
        wdata_d = i_wr_data;
        wraddr_d = {wr_bank_q, idx_w};
        sop_err_d = i_wr_sop;
        wr_idx_d = idx_w + IW'(1);
        if (!i_wr_sop && wr_idx_q == LAST) begin
          set_pend_d = 1'b1;
          set_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          wst_d = W_IDLE;
        end
      end
    end else if (i_wr_vld && i_wr_sop) begin
      if (bank_full_q[wr_bank_q]) begin
        drop_d = 1'b1;
        drop_cnt_d = &drop_cnt_q ? drop_cnt_q : drop_cnt_q + DROP_CNT_W'(1);
        wst_d = W_DROP;
      end else begin
        wren_d = 1'b1;
        wdata_d = i_wr_data;
        wraddr_d = {wr_bank_q, {IW{1'b0}}};
        wr_idx_d = IW'(1);
        wst_d = W_FILL;
      end
    end
  end
  always_comb begin
    rdst_d = rdst_q;
    rd_bank_d = rd_bank_q;
    rden_d = 1'b0;
    rdaddr_d = rdaddr_q;
    clr = 1'b0;
    if (rdst_q == R_IDLE) begin
      if (bank_full_q[rd_bank_q]) begin
        rdst_d = R_READ;
        rden_d = 1'b1;
        rdaddr_d = {rd_bank_q, {IW{1'b0}}};
      end
    end else if (rdaddr_q[IW-1:0] == LAST) begin
      clr = 1'b1;
      rd_bank_d = ~rd_bank_q;
      rdst_d = R_IDLE;
    end else begin
      rden_d = 1'b1;
      rdaddr_d = rdaddr_q + AW'(1);
    end
  end
  // The set targets the bank just filled and the clear the bank being read, so they never collide.
  always_comb begin
    bank_full_d = bank_full_q;
    if (clr) bank_full_d[rd_bank_q] = 1'b0;
    if (set_pend_q) bank_full_d[set_bank_q] = 1'b1;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wst_q <= W_IDLE;
      rdst_q <= R_IDLE;
      bank_full_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q <= '0;
      set_pend_q <= 1'b0;
      set_bank_q <= 1'b0;
      drop_cnt_q <= '0;
      drop_q <= 1'b0;
      sop_err_q <= 1'b0;
      wren_q <= 1'b0;
      wraddr_q <= '0;
      wdata_q <= '0;
      rden_q <= 1'b0;
      rdaddr_q <= '0;
    end else begin
      wst_q <= wst_d;
      rdst_q <= rdst_d;
      bank_full_q <= bank_full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q <= wr_idx_d;
      set_pend_q <= set_pend_d;
      set_bank_q <= set_bank_d;
      drop_cnt_q <= drop_cnt_d;
      drop_q <= drop_d;
      sop_err_q <= sop_err_d;
      wren_q <= wren_d;
      wraddr_q <= wraddr_d;
      wdata_q <= wdata_d;
      rden_q <= rden_d;
      rdaddr_q <= rdaddr_d;
    end
  end
  lat_align_sr #(.RD_LAT(RD_LAT)) u_lat (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_din  ({rden_q, rden_q && rdaddr_q[IW-1:0] == '0, rden_q && rdaddr_q[IW-1:0] == LAST}),
    .o_dout (sr_out)
  );
  assign {o_rd_vld, o_rd_sop, o_rd_eop} = sr_out;
  assign o_rd_data = i_ram_q;
  assign o_ram_wren = wren_q;
  assign o_ram_wraddr = wraddr_q;
  assign o_ram_wdata = wdata_q;
  assign o_ram_rden = rden_q;
  assign o_ram_rdaddr = rdaddr_q;
  assign o_bank_full = bank_full_q;
  assign o_drop = drop_q;
  assign o_sop_err = sop_err_q;
  assign o_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_pingpong_bram_ctrl.sv
// tb_pingpong_bram_ctrl: scoreboard bench for the ping-pong controller with a behavioural BRAM model.
module tb_pingpong_bram_ctrl;
  localparam int DW = 32, DEPTH = 8, RD_LAT = 4, AW = 4;
  typedef struct packed {logic [DW-1:0] d; logic s; logic e;} exp_t;
  logic i_clk = 1'b0, i_reset = 1'b1, i_wr_vld = 1'b0, i_wr_sop = 1'b0;
  logic [DW-1:0] i_wr_data = '0, i_ram_q, o_ram_wdata, o_rd_data;
  logic o_ram_wren, o_ram_rden, o_rd_vld, o_rd_sop, o_rd_eop, o_drop, o_sop_err;
  logic [AW-1:0] o_ram_wraddr, o_ram_rdaddr;
  logic [1:0] o_bank_full;
  logic [15:0] o_drop_cnt;
  logic [DW-1:0] mem [2*DEPTH];
  logic [DW-1:0] pipe [RD_LAT];
  exp_t q[$];
  logic bank_log[$];
  int checks = 0, errors = 0, drop_seen = 0, err_seen = 0, vld_seen = 0;

  pingpong_bram_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wr_vld(i_wr_vld), .i_wr_sop(i_wr_sop),
    .i_wr_data(i_wr_data), .o_ram_wren(o_ram_wren), .o_ram_wraddr(o_ram_wraddr),
    .o_ram_wdata(o_ram_wdata), .o_ram_rden(o_ram_rden), .o_ram_rdaddr(o_ram_rdaddr),
    .i_ram_q(i_ram_q), .o_rd_vld(o_rd_vld), .o_rd_sop(o_rd_sop), .o_rd_eop(o_rd_eop),
    .o_rd_data(o_rd_data), .o_bank_full(o_bank_full), .o_drop(o_drop),
    .o_sop_err(o_sop_err), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_ram_wren) mem[o_ram_wraddr] <= o_ram_wdata;
    pipe[0] <= o_ram_rden ? mem[o_ram_rdaddr] : '0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign i_ram_q = pipe[RD_LAT-1];

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, x);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        if (o_drop) drop_seen++;
        if (o_sop_err) err_seen++;
        if (o_ram_rden && o_ram_rdaddr[AW-2:0] == '0) bank_log.push_back(o_ram_rdaddr[AW-1]);
        if (o_rd_vld) begin
          vld_seen++;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected got d=%0d exp no output", o_rd_data);
          end else begin
            e = q.pop_front();
            if ({o_rd_data, o_rd_sop, o_rd_eop} !== e) begin
              errors++;
              $display("FAIL rd_word got d=%0d s=%0b e=%0b exp d=%0d s=%0b e=%0b",
                       o_rd_data, o_rd_sop, o_rd_eop, e.d, e.s, e.e);
            end
          end
        end
      end
    end
  endtask

  task automatic word(logic s, logic [DW-1:0] d);
    i_wr_vld = 1'b1;
    i_wr_sop = s;
    i_wr_data = d;
    tick();
    i_wr_vld = 1'b0;
    i_wr_sop = 1'b0;
  endtask

  task automatic push_frame(logic [DW-1:0] b);
    for (int i = 0; i < DEPTH; i++) q.push_back({b + DW'(i), i == 0, i == DEPTH - 1});
  endtask

  task automatic frame(logic [DW-1:0] b);
    for (int i = 0; i < DEPTH; i++) word(i == 0, b + DW'(i));
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    q.delete();
    bank_log.delete();
    drop_seen = 0;
    err_seen = 0;
    i_reset = 1'b0;
    tick();
  endtask

  task automatic drain(string n);
    int k = 0;
    while (q.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    chk(n, q.size(), 0);
    repeat (5) tick();
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none
    tick();
    tick();
    // reset state
    chk("rst_wren", o_ram_wren, 0);
    chk("rst_rden", o_ram_rden, 0);
    chk("rst_vld", o_rd_vld, 0);
    chk("rst_full", o_bank_full, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_sop_err", o_sop_err, 0);
    chk("rst_drop_cnt", o_drop_cnt, 0);
    i_reset = 1'b0;
    tick();

    // single frame 0..7 and its latency
    push_frame(0);
    frame(0);
    n = 1;
    while (!o_rd_vld && n < 50) begin
      tick();
      n++;
    end
    chk("latency", n, 3 + RD_LAT);
    drain("drain_single");
    chk("single_no_drop", o_drop_cnt, 0);

    // three frames with short gaps: bank order 0,1,0, no drop
    do_reset();
    for (int f = 0; f < 3; f++) begin
      push_frame(100 + 16 * f);
      frame(100 + 16 * f);
      tick();
      tick();
    end
    drain("drain_b2b");
    chk("b2b_banks", bank_log.size(), 3);
    if (bank_log.size() == 3) chk("b2b_order", {bank_log[0], bank_log[1], bank_log[2]}, 3'b010);
    chk("b2b_drops", drop_seen, 0);
    chk("b2b_drop_cnt", o_drop_cnt, 0);

    // third frame hits two full banks and is dropped; fourth is accepted
    do_reset();
    push_frame(200);
    push_frame(300);
    frame(200);
    frame(300);
    frame(400);
    n = 0;
    while (o_bank_full[0] && n < 100) begin
      tick();
      n++;
    end
    push_frame(500);
    frame(500);
    drain("drain_drop");
    chk("drop_pulses", drop_seen, 1);
    chk("drop_cnt", o_drop_cnt, 1);

    // sop at word 5 restarts the frame
    do_reset();
    for (int i = 0; i < 5; i++) word(i == 0, 600 + i);
    push_frame(700);
    frame(700);
    drain("drain_sop_err");
    chk("sop_err_pulses", err_seen, 1);
    chk("sop_err_drops", drop_seen, 0);

    // reset during word 3 of a read
    do_reset();
    push_frame(800);
    frame(800);
    n = 0;
    while (!(o_rd_vld && o_rd_data == 803) && n < 100) begin
      tick();
      n++;
    end
    chk("mid_read_reached", n < 100, 1);
    chk("pre_rst_drop_cnt", o_drop_cnt, 0);
    #1 i_reset = 1'b1;
    #1;
    q.delete();
    chk("async_vld", o_rd_vld, 0);
    chk("async_rden", o_ram_rden, 0);
    chk("async_rdaddr", o_ram_rdaddr, 0);
    chk("async_sop_eop", {o_rd_sop, o_rd_eop}, 0);
    chk("async_full", o_bank_full, 0);
    tick();
    tick();
    i_reset = 1'b0;
    vld_seen = 0;
    repeat (30) tick();
    chk("no_vld_after_rst", vld_seen, 0);
    push_frame(900);
    frame(900);
    drain("drain_after_rst");

    // drop counter saturation
    do_reset();
    dut.drop_cnt_q = 16'hFFFE;
    push_frame(1000);
    push_frame(1100);
    frame(1000);
    frame(1100);
    word(1, 1200);
    word(1, 1201);
    for (int i = 2; i < DEPTH; i++) word(0, 1200 + i);
    drain("drain_sat");
    chk("sat_pulses", drop_seen, 2);
    chk("sat_cnt", o_drop_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
